// File: rtl/bus_data_ram.sv
// Word-organised data RAM responding on the CPU data bus: one load/store at a time,
// per-lane store enables, programmable wait states and a one-cycle ready strobe.
module bus_data_ram #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busSel,
   input  logic        busWe,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWData,
   input  logic [3:0]  Byte_Enable,
   output logic [31:0] busRData,
   output logic        busReady,
   output logic        busErr,
   output logic        busBusy
);

   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   localparam int unsigned TAG_LO = ADDR_WIDTH + 2;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    we_q, we_d;
   logic                    inr_q, inr_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              be_q, be_d;
   logic [31:0]             rdata_d;
   logic                    ready_d, err_d, busy_d;
   logic                    req_inr_c;

   logic [31:0] mem [DEPTH];

   // Byte offset is the master's concern; the RAM only works on whole words.
   logic unused_addr_bits;
   assign unused_addr_bits = ^busAddr[1:0];

   assign req_inr_c = (busAddr[31:TAG_LO] == BASE_ADDR[31:TAG_LO]);

   // Next-state, request capture and registered-output values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      inr_d   = inr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = 32'h0;
      ready_d = 1'b0;
      err_d   = 1'b0;
      busy_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (busSel) begin
               we_d    = busWe;
               inr_d   = req_inr_c;
               idx_d   = busAddr[TAG_LO-1:2];
               wdata_d = busWData;
               be_d    = Byte_Enable;
               cnt_d   = CNT_W'(WAIT_STATES);
               state_d = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            if (cnt_q <= CNT_W'(1)) state_d = RESP;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Response fields are registered on the edge that enters RESP.
      if (state_d == RESP) begin
         ready_d = 1'b1;
         err_d   = ~inr_d;
         if (!we_d && inr_d) rdata_d = mem[idx_d];
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         inr_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         busRData <= '0;
         busReady <= 1'b0;
         busErr   <= 1'b0;
         busBusy  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         inr_q    <= inr_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         busRData <= rdata_d;
         busReady <= ready_d;
         busErr   <= err_d;
         busBusy  <= busy_d;
      end
   end

   // Store commits at the end of RESP; a reset on that edge discards it.
   always_ff @(posedge clk) begin
      if (reset && (state_q == RESP) && we_q && inr_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_bus_data_ram.sv
// Scoreboard bench for bus_data_ram: three instances (1, 0 and 3 wait states)
// share the bus wires but have private selects.
module tb_bus_data_ram;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk;
   logic        reset;
   logic [2:0]  sel;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata [3];
   logic        ready [3];
   logic        err   [3];
   logic        busy  [3];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int          d;
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb [$];
   exp_t        mon_e;
   logic [31:0] model [3][256];

   bus_data_ram #(.ADDR_WIDTH(8), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_ram0 (
      .clk(clk), .reset(reset), .busSel(sel[0]), .busWe(we), .busAddr(addr),
      .busWData(wdata), .Byte_Enable(be), .busRData(rdata[0]), .busReady(ready[0]),
      .busErr(err[0]), .busBusy(busy[0]));

   bus_data_ram #(.ADDR_WIDTH(8), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ram1 (
      .clk(clk), .reset(reset), .busSel(sel[1]), .busWe(we), .busAddr(addr),
      .busWData(wdata), .Byte_Enable(be), .busRData(rdata[1]), .busReady(ready[1]),
      .busErr(err[1]), .busBusy(busy[1]));

   bus_data_ram #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_ram2 (
      .clk(clk), .reset(reset), .busSel(sel[2]), .busWe(we), .busAddr(addr),
      .busWData(wdata), .Byte_Enable(be), .busRData(rdata[2]), .busReady(ready[2]),
      .busErr(err[2]), .busBusy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int ws_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 0 : 3;
   endfunction

   // Compute the expected response for a request accepted at the next edge.
   task automatic push(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] b);
      exp_t e;
      int   idx;
      idx     = int'(a[9:2]);
      e.d     = d;
      e.due   = cyc + 1 + ws_of(d);
      e.rdata = 32'h0;
      e.err   = (a[31:10] != BASE[31:10]);
      if (!e.err) begin
         if (w) begin
            for (int i = 0; i < 4; i++)
               if (b[i]) model[d][idx][8*i +: 8] = wd[8*i +: 8];
         end else begin
            e.rdata = model[d][idx];
         end
      end
      sb.push_back(e);
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b);
      we = w; addr = a; wdata = wd; be = b;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic req(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b);
      @(negedge clk);
      drive(w, a, wd, b);
      sel[d] = 1'b1;
      push(d, w, a, wd, b);
      @(negedge clk);
      check("busy_rise", 64'(busy[d]), 64'd1);
      sel[d] = 1'b0;
      drain();
   endtask

   // Response monitor: pops the scoreboard on every ready strobe.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ready[d]) begin
            if (sb.size() == 0) begin
               check("spurious_ready", 64'(d + 1), 64'd0);
            end else begin
               mon_e = sb.pop_front();
               check("resp_dut", 64'(d), 64'(mon_e.d));
               check("latency", 64'(cyc), 64'(mon_e.due));
               check("rdata", 64'(rdata[d]), 64'(mon_e.rdata));
               check("err", 64'(err[d]), 64'(mon_e.err));
            end
         end else begin
            check("quiet_out", 64'({err[d], rdata[d]}), 64'd0);
         end
      end
   end

   logic        cw  [7];
   logic [31:0] ca  [7];
   logic [31:0] cd  [7];

   initial begin
      reset = 1'b0;
      sel   = 3'b000;
      drive(1'b0, BASE, 32'h0, 4'h0);

      // Reset holds off a request that is already asserted.
      sel[0] = 1'b1;
      drive(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'b0000);
      repeat (3) begin
         @(negedge clk);
         check("rst_busy", 64'(busy[0]), 64'd0);
         check("rst_ready", 64'(ready[0]), 64'd0);
      end
      reset = 1'b1;
      push(0, 1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'b0000);
      @(negedge clk);
      check("busy_after_release", 64'(busy[0]), 64'd1);
      sel[0] = 1'b0;
      drain();

      // Word store/load and byte lanes, one wait state.
      req(0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111);
      req(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000);
      req(0, 1'b0, BASE + 32'h13, 32'h0, 4'b0000);
      req(0, 1'b1, BASE + 32'h20, 32'h1122_3344, 4'b1111);
      req(0, 1'b1, BASE + 32'h20, 32'h00AA_0000, 4'b0100);
      req(0, 1'b0, BASE + 32'h20, 32'h0, 4'b1111);
      req(0, 1'b1, BASE + 32'h20, 32'hBBBB_0000, 4'b1100);
      req(0, 1'b0, BASE + 32'h20, 32'h0, 4'b0001);
      req(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000);
      req(0, 1'b0, BASE + 32'h20, 32'h0, 4'b0000);
      check("lane_model", 64'(model[0][8]), 64'h0000_0000_BBBB_3344);

      // Out of range leaves the aliased word untouched.
      req(0, 1'b1, BASE, 32'hCAFE_F00D, 4'b1111);
      req(0, 1'b0, BASE + 32'h400, 32'h0, 4'b1111);
      req(0, 1'b1, BASE + 32'h400, 32'h1234_5678, 4'b1111);
      req(0, 1'b0, BASE, 32'h0, 4'b0000);

      // Zero wait states with select held: accept every other cycle, RESP-cycle values ignored.
      cw[0] = 1'b1; ca[0] = BASE + 32'h30;  cd[0] = 32'hA5A5_0001;
      cw[1] = 1'b0; ca[1] = BASE + 32'h30;  cd[1] = 32'h0;
      cw[2] = 1'b1; ca[2] = BASE + 32'h30;  cd[2] = 32'h1234_0000;
      cw[3] = 1'b0; ca[3] = BASE + 32'h30;  cd[3] = 32'h0;
      cw[4] = 1'b0; ca[4] = BASE + 32'h400; cd[4] = 32'h0;
      cw[5] = 1'b1; ca[5] = BASE + 32'h34;  cd[5] = 32'h7777_8888;
      cw[6] = 1'b0; ca[6] = BASE + 32'h34;  cd[6] = 32'h0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         sel[1] = 1'b1;
         if (k % 2 == 0) begin
            drive(cw[k/2], ca[k/2], cd[k/2], (k == 4) ? 4'b1100 : 4'b1111);
            push(1, cw[k/2], ca[k/2], cd[k/2], (k == 4) ? 4'b1100 : 4'b1111);
         end else begin
            drive(1'b1, BASE + 32'h30, 32'hFFFF_FFFF, 4'b1111);
         end
      end
      @(negedge clk);
      sel[1] = 1'b0;
      drain();
      req(1, 1'b0, BASE + 32'h30, 32'h0, 4'b0000);

      // Three wait states: reset in the 2nd WAIT cycle aborts a pending store.
      req(2, 1'b1, BASE + 32'h50, 32'h0000_0000, 4'b1111);
      req(2, 1'b0, BASE + 32'h50, 32'h0, 4'b0000);
      @(negedge clk);
      drive(1'b1, BASE + 32'h50, 32'h5555_5555, 4'b1111);
      sel[2] = 1'b1;
      @(negedge clk);
      sel[2] = 1'b0;
      check("abort_busy", 64'(busy[2]), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_idle", 64'(busy[2]), 64'd0);
      repeat (6) @(negedge clk);
      req(2, 1'b0, BASE + 32'h50, 32'h0, 4'b0000);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
